// File: rtl/reg_desp_pkg.sv
// Shared encodings for the reg_desp shift register and its sequencing controller.
package reg_desp_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SHIFT = 2'b00;
    localparam mode_t MODE_ROT   = 2'b01;
    localparam mode_t MODE_LOAD  = 2'b10;
    localparam mode_t MODE_HOLD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/reg_desp.sv
// Universal shift register: shift/rotate in either direction, parallel load or hold.
module reg_desp
    import reg_desp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enb,
    input  logic             i_dir,
    input  mode_t            i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_s_in,
    output logic [WIDTH-1:0] o_q,
    output logic             o_s_out
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_enb) begin
            case (i_mode)
                MODE_SHIFT: r_q <= i_dir ? {i_s_in, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], i_s_in};
                MODE_ROT:   r_q <= i_dir ? {r_q[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                MODE_LOAD:  r_q <= i_d;
                default:    r_q <= r_q;
            endcase
        end
    end

    // The bit leaving the register on the next shift, so the controller can sample it pre-edge.
    assign o_q     = r_q;
    assign o_s_out = i_dir ? r_q[0] : r_q[WIDTH-1];

endmodule

// File: rtl/reg_desp_xcvr.sv
// Full-duplex word transceiver: the controller closed around its shift register.
module reg_desp_xcvr
    import reg_desp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_dir_req,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rx_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_tx_bit,
    output logic             o_tx_valid,
    output logic [WIDTH-1:0] o_rx_word
);

    logic             w_enb;
    logic             w_dir;
    mode_t            w_mode;
    logic [WIDTH-1:0] w_d;
    logic             w_s_in;
    logic [WIDTH-1:0] w_q;
    logic             w_s_out;

    reg_desp_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_dir_req  (i_dir_req),
        .i_data     (i_data),
        .i_rx_in    (i_rx_in),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_tx_bit   (o_tx_bit),
        .o_tx_valid (o_tx_valid),
        .o_rx_word  (o_rx_word),
        .o_enb      (w_enb),
        .o_dir      (w_dir),
        .o_mode     (w_mode),
        .o_d        (w_d),
        .o_s_in     (w_s_in),
        .i_q        (w_q),
        .i_s_out    (w_s_out)
    );

    reg_desp #(.WIDTH(WIDTH)) u_reg (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_enb   (w_enb),
        .i_dir   (w_dir),
        .i_mode  (w_mode),
        .i_d     (w_d),
        .i_s_in  (w_s_in),
        .o_q     (w_q),
        .o_s_out (w_s_out)
    );

endmodule

// File: rtl/reg_desp_ctrl.sv
// Sequencer that loads a word into reg_desp, shifts it out WIDTH times while
// shifting rx_in in, and returns the received word with a done pulse.
module reg_desp_ctrl
    import reg_desp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_dir_req,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rx_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_tx_bit,
    output logic             o_tx_valid,
    output logic [WIDTH-1:0] o_rx_word,
    output logic             o_enb,
    output logic             o_dir,
    output mode_t            o_mode,
    output logic [WIDTH-1:0] o_d,
    output logic             o_s_in,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_s_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_data_q;
    logic             r_dir_q;
    logic             r_enb;
    mode_t            r_mode;
    logic             r_done;
    logic             r_tx_bit;
    logic             r_tx_valid;
    logic [WIDTH-1:0] r_rx_word;

    // Control outputs are registered one state ahead so they are valid for the whole state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_data_q   <= '0;
            r_dir_q    <= 1'b0;
            r_enb      <= 1'b0;
            r_mode     <= MODE_HOLD;
            r_done     <= 1'b0;
            r_tx_bit   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_rx_word  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_tx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_data_q <= i_data;
                        r_dir_q  <= i_dir_req;
                        r_enb    <= 1'b1;
                        r_mode   <= MODE_LOAD;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    r_mode  <= MODE_SHIFT;
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_tx_bit   <= i_s_out;
                    r_tx_valid <= 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_enb   <= 1'b0;
                        r_mode  <= MODE_HOLD;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_rx_word <= i_q;
                    r_done    <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_enb   <= 1'b0;
                    r_mode  <= MODE_HOLD;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy     = (r_state != IDLE);
    assign o_done     = r_done;
    assign o_tx_bit   = r_tx_bit;
    assign o_tx_valid = r_tx_valid;
    assign o_rx_word  = r_rx_word;
    assign o_enb      = r_enb;
    assign o_dir      = r_dir_q;
    assign o_mode     = r_mode;
    assign o_d        = r_data_q;
    // Serial input passes straight through so the bit present in a SHIFT cycle is the one captured.
    assign o_s_in     = (r_state == SHIFT) & i_rx_in;

endmodule

// File: tb/tb_reg_desp_ctrl.sv
// Directed bench for reg_desp_ctrl closed around reg_desp, with a cycle-stamped scoreboard.
module tb_reg_desp_ctrl;
    import reg_desp_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, start, dir_req, rx_in;
    logic [W-1:0] data;
    logic         busy, done, tx_bit, tx_valid, enb, dir, s_in, s_out;
    logic [W-1:0] rx_word, d, q;
    mode_t        mode;

    always #5 clk = ~clk;

    reg_desp_ctrl #(.WIDTH(W)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_dir_req(dir_req),
        .i_data(data), .i_rx_in(rx_in), .o_busy(busy), .o_done(done),
        .o_tx_bit(tx_bit), .o_tx_valid(tx_valid), .o_rx_word(rx_word),
        .o_enb(enb), .o_dir(dir), .o_mode(mode), .o_d(d), .o_s_in(s_in),
        .i_q(q), .i_s_out(s_out)
    );

    reg_desp #(.WIDTH(W)) u_reg (
        .i_clk(clk), .i_reset(reset), .i_enb(enb), .i_dir(dir), .i_mode(mode),
        .i_d(d), .i_s_in(s_in), .o_q(q), .o_s_out(s_out)
    );

    typedef struct { int cyc; logic b; }         tx_t;
    typedef struct { int cyc; logic [W-1:0] w; } rx_t;

    tx_t          txq[$];
    rx_t          rxq[$];
    int           cyc, acc, ndone, tests, fails, base;
    logic [W-1:0] md, mrxw;
    logic         mdir;
    logic         rx_arr [0:1023];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected tx bits, done cycle and received word for a start accepted in this cycle.
    task automatic accept();
        logic [W-1:0] w;
        w    = '0;
        acc  = cyc;
        md   = data;
        mdir = dir_req;
        for (int k = 0; k < W; k++) begin
            txq.push_back('{cyc + 3 + k, dir_req ? data[k] : data[W-1-k]});
            if (dir_req) w[k] = rx_arr[cyc + 2 + k];
            else         w[W-1-k] = rx_arr[cyc + 2 + k];
        end
        rxq.push_back('{cyc + W + 3, w});
    endtask

    task automatic monitor();
        int    ph;
        mode_t em;
        logic  shifting;
        ph       = cyc - acc;
        shifting = (ph >= 2) && (ph <= W + 1);
        em       = (ph == 1) ? MODE_LOAD : shifting ? MODE_SHIFT : MODE_HOLD;
        chk("busy", busy, (ph >= 1) && (ph <= W + 2));
        chk("enb", enb, (ph >= 1) && (ph <= W + 1));
        chk("mode", mode, em);
        chk("dir", dir, mdir);
        chk("d", d, md);
        chk("s_in", s_in, shifting ? rx_in : 1'b0);
        if (txq.size() > 0 && txq[0].cyc == cyc) begin
            chk("tx_valid", tx_valid, 1);
            chk("tx_bit", tx_bit, txq[0].b);
            void'(txq.pop_front());
        end else begin
            chk("tx_valid_idle", tx_valid, 0);
        end
        if (done === 1'b1) ndone++;
        if (rxq.size() > 0 && rxq[0].cyc == cyc) begin
            chk("done", done, 1);
            mrxw = rxq[0].w;
            void'(rxq.pop_front());
        end else begin
            chk("done_idle", done, 0);
        end
        chk("rx_word", rx_word, mrxw);
    endtask

    task automatic step();
        if (reset) begin
            txq.delete();
            rxq.delete();
            acc  = -100;
            md   = '0;
            mdir = 1'b0;
            mrxw = '0;
        end else if (start && cyc >= acc + W + 3) begin
            accept();
        end
        @(posedge clk);
        #1;
        cyc++;
        rx_in = rx_arr[cyc];
        #1;
        monitor();
    endtask

    initial begin
        tests = 0; fails = 0; ndone = 0; cyc = 0; acc = -100;
        md = '0; mdir = 1'b0; mrxw = '0;
        for (int i = 0; i < 1024; i++) rx_arr[i] = 1'($urandom_range(0, 1));
        reset = 1'b1; start = 1'b0; dir_req = 1'b0; data = '0; rx_in = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_mode", mode, 2'b11);
        chk("rst_enb", enb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_word", rx_word, 0);
        chk("rst_tx", {tx_bit, tx_valid, done, dir, s_in}, 0);

        // Left shift: data 1011, rx 1,1,0,0
        base = cyc;
        rx_arr[base+2] = 1'b1; rx_arr[base+3] = 1'b1; rx_arr[base+4] = 1'b0; rx_arr[base+5] = 1'b0;
        start = 1'b1; data = 4'b1011; dir_req = 1'b0;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("left_rx_word", rx_word, 4'b1100);

        // Right shift: same word and rx bits
        base = cyc;
        rx_arr[base+2] = 1'b1; rx_arr[base+3] = 1'b1; rx_arr[base+4] = 1'b0; rx_arr[base+5] = 1'b0;
        start = 1'b1; data = 4'b1011; dir_req = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("right_rx_word", rx_word, 4'b0011);

        // Starts while busy are dropped
        base = ndone;
        start = 1'b1; data = 4'h6; dir_req = 1'b0; step();
        start = 1'b0; step();
        start = 1'b1; data = 4'h9; step();
        start = 1'b0; step();
        start = 1'b1; data = 4'hF; dir_req = 1'b1; step();
        start = 1'b0;
        repeat (6) step();
        chk("busy_start_dones", ndone - base, 1);

        // Back-to-back with start held high
        base = ndone;
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data = W'($urandom);
            dir_req = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0;
        repeat (8) step();
        chk("b2b_dones", ndone - base, 3);

        // Reset during SHIFT
        base = ndone;
        start = 1'b1; data = 4'hA; dir_req = 1'b0; step();
        start = 1'b0; step(); step(); step();
        reset = 1'b1; step();
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        repeat (8) step();
        chk("midrst_dones", ndone - base, 0);
        chk("midrst_rx_word", rx_word, 0);

        // A few random transactions
        for (int t = 0; t < 5; t++) begin
            start = 1'b1; data = W'($urandom); dir_req = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
            repeat (7) step();
        end

        chk("txq_drained", txq.size(), 0);
        chk("rxq_drained", rxq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
